fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage with integrated IF/ID pipeline register. Holds the PC and issues word requests to instruction memory over a valid/ready handshake with at most one request outstanding. Delivers `instr_d`/`pc_d`/`pc_plus4_d` to the decode stage, which feeds the control unit. Handles decode stalls, EX-stage branch/jump redirects, and discarding of stale in-flight responses.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `imem_req_valid`, out, 1: request to instruction memory.
- `imem_req_ready`, in, 1: memory accepts the request this cycle.
- `imem_addr`, out, 32: word address; always `{pc_f[31:2],2'b00}`.
- `imem_rsp_valid`, in, 1: response data valid.
- `imem_rsp_data`, in, 32: fetched instruction word.
- `redirect_valid`, in, 1: branch taken or jump resolved in EX.
- `redirect_target`, in, 32: new PC.
- `stall_d`, in, 1: decode stage cannot accept; hold IF/ID.
- `instr_d`, out, 32: instruction to decode; NOP 32'h0000_0013 when `valid_d`=0.
- `pc_d`, out, 32: PC of `instr_d`.
- `pc_plus4_d`, out, 32: `pc_d + 4`, modulo 2^32.
- `valid_d`, out, 1: IF/ID holds a real instruction.

## Operation
- **State machine:** REQ (no request outstanding), WAIT (one accepted, response pending), DRAIN (one outstanding, response to be discarded).
  - REQ: assert `imem_req_valid` iff the hold buffer is empty. On `imem_req_valid & imem_req_ready`, record `pc_f` as `pc_req`, set `pc_f += 4`, and go to WAIT.
  - WAIT, on `imem_rsp_valid`: deliver `{imem_rsp_data, pc_req}`, then go to REQ. If the hold buffer stays empty and `imem_req_ready` is high, issue the next request in the same cycle and stay in WAIT (back-to-back).
  - DRAIN, on `imem_rsp_valid`: drop the data and go to REQ.
- **Delivery:** if the hold buffer is empty and (`!valid_d | !stall_d`), write into IF/ID and set `valid_d`=1. Otherwise write into the 1-entry hold buffer.
- **Hold buffer:** when IF/ID frees (`!stall_d`), the entry moves to IF/ID and the buffer empties. No request is issued while the buffer is full, so nothing is ever overwritten.
- **Decode consumption:** if `!stall_d` and there is no new entry for IF/ID, `valid_d` goes to 0 and `instr_d` to NOP.
- **Redirect** (highest priority, regardless of `stall_d`):
  - `pc_f <= redirect_target`.
  - `valid_d <= 0`, `instr_d <= NOP`; the hold buffer is cleared.
  - If in WAIT with the response not arriving this cycle, go to DRAIN.
  - If a response arrives in the same cycle as the redirect, discard it and go to REQ.
  - No request is issued in the redirect cycle.
- **Ignored responses:** `imem_rsp_valid` in REQ is ignored (covers responses left over across reset).
- **Target alignment:** `redirect_target[1:0]` is stored but masked on `imem_addr`; `pc_d` carries the unmasked value.

## Timing
- **Reset values:**
  - `pc_f`=RESET_PC, state REQ, hold empty.
  - `valid_d`=0, `instr_d`=32'h0000_0013, `pc_d`=0, `pc_plus4_d`=4.
  - `imem_req_valid`=0 during the reset cycle, 1 in the first cycle after reset.
- **Latency:** request accepted in cycle N, response in N+k (k≥1), `instr_d` visible in N+k+1.
- **Throughput:** with k=1 and `imem_req_ready` always 1, one instruction per cycle.
- **Redirect in cycle R:** first request to the target is in R+1; the earliest valid target instruction appears in R+3 with k=1. Longer with DRAIN.
- **Stall:** while `stall_d`=1 and there is no redirect, `instr_d`, `pc_d`, `pc_plus4_d` and `valid_d` are held stable.
- **Reset mid-operation:** outstanding and buffered state is discarded in one cycle. There is no DRAIN after reset.

## Structure
- **Package `fetch_pkg`:**
  - `localparam NOP_INSTR = 32'h0000_0013`.
  - `typedef enum logic [1:0] {F_REQ, F_WAIT, F_DRAIN} fetch_state_t`.
  - `typedef struct packed {logic [31:0] instr; logic [31:0] pc;} fetch_entry_t`.
- **Sub-module `if_hold_buffer`:** a 1-entry skid buffer of `fetch_entry_t` with `push`, `pop`, `clear` and `full`.

## Test plan
- **Basic fetch:** reset, memory with k=1 and ready=1 holding words at 0x0/0x4/0x8 → `valid_d`=1 on consecutive cycles with `pc_d`=0,4,8 and `pc_plus4_d`=4,8,C.
- **Stall during wait:** `stall_d`=1 for 3 cycles while a response arrives → IF/ID holds 0x4; 0x8 goes to the hold buffer; no new request is issued; after release the sequence continues 0x8, 0xC with no loss or duplication.
- **Redirect with outstanding request:** `redirect_valid`=1 with target 0x100 while in WAIT, k=3 → the response at 0x8 is discarded, `valid_d`=0 (`instr_d`=0x13), and the next `imem_addr`=0x100.
- **Redirect with stall and full buffer:** redirect arrives in the same cycle as `stall_d`=1 with the hold buffer full → buffer cleared, `valid_d`=0, and the next delivered `pc_d` is the target.
- **Reset mid-flight:** `rst` with a request outstanding; a stale `imem_rsp_valid` arrives in the first cycle after reset → ignored, first `pc_d`=RESET_PC.
- **Backpressure and wrap:** `imem_req_ready`=0 for 5 cycles → `imem_addr` held stable. Separately, a redirect to 0xFFFF_FFFC → `pc_plus4_d`=0x0.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage.
package fetch_pkg;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  typedef enum logic [1:0] {F_REQ, F_WAIT, F_DRAIN} fetch_state_t;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/if_hold_buffer.sv
// if_hold_buffer: single-entry skid buffer that catches a fetched word while IF/ID is stalled.
module if_hold_buffer
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         clear_i,
  input  fetch_entry_t entry_i,
  output fetch_entry_t entry_o,
  output logic         full_o
);
  logic         full_q;
  fetch_entry_t entry_q;
  always_ff @(posedge clk) begin
    if (rst || clear_i) full_q <= 1'b0;
    else if (push_i) full_q <= 1'b1;
    else if (pop_i) full_q <= 1'b0;
    if (push_i) entry_q <= entry_i;
  end
  assign entry_o = entry_q;
  assign full_o  = full_q;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC, single-outstanding imem handshake and IF/ID register with stall/redirect handling.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        stall_d,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc_plus4_d,
  output logic        valid_d
);
  fetch_state_t state_q, state_d;
  fetch_entry_t if_q, hold_entry;
  logic [31:0]  pc_f_q, pc_req_q;
  logic         valid_q, hold_full, deliver, to_if, push, pop, req_fire;
  assign deliver        = state_q == F_WAIT && imem_rsp_valid && !redirect_valid;
  assign to_if          = deliver && !hold_full && (!valid_q || !stall_d);
  assign push           = deliver && !to_if;
  assign pop            = hold_full && !stall_d && !redirect_valid;
  // to_if only fires in WAIT, giving the back-to-back request on a direct delivery
  assign imem_req_valid = !rst && !redirect_valid && !hold_full && (state_q == F_REQ || to_if);
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign imem_addr      = {pc_f_q[31:2], 2'b00};
  assign instr_d        = if_q.instr;
  assign pc_d           = if_q.pc;
  assign pc_plus4_d     = if_q.pc + 32'd4;
  assign valid_d        = valid_q;
  if_hold_buffer u_hold (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .clear_i (redirect_valid),
    .entry_i ({imem_rsp_data, pc_req_q}),
    .entry_o (hold_entry),
    .full_o  (hold_full)
  );
  always_comb begin
    state_d = state_q;
    if (redirect_valid) state_d = (state_q != F_REQ && !imem_rsp_valid) ? F_DRAIN : F_REQ;
    else if (req_fire) state_d = F_WAIT;
    else if (state_q != F_REQ && imem_rsp_valid) state_d = F_REQ;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= F_REQ;
      pc_f_q   <= RESET_PC;
      pc_req_q <= RESET_PC;
      valid_q  <= 1'b0;
      if_q     <= {NOP_INSTR, 32'h0};
    end else begin
      state_q <= state_d;
      pc_f_q  <= redirect_valid ? redirect_target : req_fire ? pc_f_q + 32'd4 : pc_f_q;
      if (req_fire) pc_req_q <= pc_f_q;
      if (redirect_valid) begin
        valid_q    <= 1'b0;
        if_q.instr <= NOP_INSTR;
      end else if (pop) begin
        valid_q <= 1'b1;
        if_q    <= hold_entry;
      end else if (to_if) begin
        valid_q <= 1'b1;
        if_q    <= {imem_rsp_data, pc_req_q};
      end else if (!stall_d) begin
        valid_q    <= 1'b0;
        if_q.instr <= NOP_INSTR;
      end
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios with an imem model and an IF/ID scoreboard.
module tb_fetch_stage;
  import fetch_pkg::*;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  logic        clk = 0, rst = 1, imem_req_ready = 1, imem_rsp_valid = 0, redirect_valid = 0, stall_d = 0;
  logic [31:0] imem_rsp_data = 0, redirect_target = 0;
  logic        imem_req_valid, valid_d;
  logic [31:0] imem_addr, instr_d, pc_d, pc_plus4_d;
  int          checks = 0, failures = 0, k = 1, rem = 0;
  logic        pend = 0, stale = 0;
  logic [31:0] pend_pc = 0, exp_pc = RST_PC;
  logic [63:0] q[$];

  fetch_stage #(.RESET_PC(RST_PC)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_addr       (imem_addr),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .stall_d         (stall_d),
    .instr_d         (instr_d),
    .pc_d            (pc_d),
    .pc_plus4_d      (pc_plus4_d),
    .valid_d         (valid_d)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: memory handshake, scoreboard push before the edge, IF/ID check after it.
  task automatic cyc();
    logic acc, consumed, p_valid, p_stall, p_redir, was_rst;
    logic [31:0] p_instr, p_pc, p_tgt;
    logic [63:0] e;
    #1;
    acc = imem_req_valid && imem_req_ready;
    if (acc) chk("req_addr", imem_addr, {exp_pc[31:2], 2'b00});
    consumed = imem_rsp_valid && pend && rem == 1;
    if (consumed && !stale && !redirect_valid && !rst) q.push_back({memf(pend_pc), pend_pc});
    p_valid = valid_d; p_stall = stall_d; p_redir = redirect_valid; p_tgt = redirect_target;
    p_instr = instr_d; p_pc = pc_d; was_rst = rst;
    @(posedge clk);
    #1;
    if (consumed) pend = 0;
    else if (pend) rem--;
    if (acc) begin pend = 1; rem = k; pend_pc = exp_pc; stale = 0; exp_pc += 32'd4; end
    if (p_redir) begin exp_pc = p_tgt; stale = pend; q.delete(); end
    if (was_rst) begin exp_pc = RST_PC; pend = 0; q.delete(); end
    imem_rsp_valid = pend && rem == 1;
    imem_rsp_data  = pend ? memf(pend_pc) : 32'h0;
    if (!was_rst) begin
      chk("pc_plus4", pc_plus4_d, pc_d + 32'd4);
      if (p_valid && p_stall && !p_redir) begin
        chk("hold_valid", valid_d, 1);
        chk("hold_instr", instr_d, p_instr);
        chk("hold_pc", pc_d, p_pc);
      end else if (!valid_d) chk("nop", instr_d, NOP_INSTR);
      else if (q.size() == 0) chk("unexpected_valid", valid_d, 0);
      else begin
        e = q.pop_front();
        chk("instr", instr_d, e[63:32]);
        chk("pc", pc_d, e[31:0]);
      end
    end
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!valid_d && n < 12) begin cyc(); n++; end
    chk(tag, valid_d, 1);
  endtask

  initial begin
    int n;
    // reset
    #1 chk("req_valid_in_reset", imem_req_valid, 0);
    cyc();
    chk("rst_valid", valid_d, 0);
    chk("rst_instr", instr_d, NOP_INSTR);
    chk("rst_pc", pc_d, 32'h0);
    chk("rst_pc4", pc_plus4_d, 32'h4);
    chk("rst_addr", imem_addr, RST_PC);
    rst = 0;
    #1 chk("req_valid_after_reset", imem_req_valid, 1);
    // basic fetch: one per cycle
    cyc();
    chk("first_not_yet", valid_d, 0);
    repeat (4) begin cyc(); chk("stream_valid", valid_d, 1); end
    chk("stream_pc", pc_d, 32'hC);
    // stall during wait
    stall_d = 1;
    repeat (3) begin #1 chk("no_req_stall", imem_req_valid, 0); cyc(); end
    chk("stall_hold_pc", pc_d, 32'hC);
    stall_d = 0;
    cyc();
    chk("release_pc", pc_d, 32'h10);
    repeat (3) cyc();
    // redirect while a k=3 request is outstanding
    k = 3;
    n = 0;
    while (!(pend && rem > 1) && n < 20) begin cyc(); n++; end
    chk("reach_wait", n < 20, 1);
    redirect_valid = 1; redirect_target = 32'h100;
    #1 chk("no_req_redirect", imem_req_valid, 0);
    cyc();
    redirect_valid = 0;
    chk("redir_valid", valid_d, 0);
    chk("redir_nop", instr_d, NOP_INSTR);
    n = 0;
    while (!imem_req_valid && n < 10) begin cyc(); n++; end
    chk("req_after_redirect", imem_req_valid, 1);
    chk("redirect_addr", imem_addr, 32'h100);
    wait_valid("tgt_valid");
    chk("tgt_pc", pc_d, 32'h100);
    k = 1;
    repeat (4) cyc();
    // redirect under stall with a full hold buffer
    n = 0;
    while (!(valid_d && pend && rem == 1) && n < 20) begin cyc(); n++; end
    chk("reach_stream", n < 20, 1);
    stall_d = 1;
    cyc(); cyc();
    redirect_valid = 1; redirect_target = 32'h200;
    cyc();
    redirect_valid = 0;
    chk("flush_valid", valid_d, 0);
    chk("flush_nop", instr_d, NOP_INSTR);
    stall_d = 0;
    wait_valid("flush_tgt_valid");
    chk("flush_tgt_pc", pc_d, 32'h200);
    // reset mid-flight with a stale response right after
    k = 3;
    n = 0;
    while (!(pend && rem > 1) && n < 20) begin cyc(); n++; end
    chk("reach_wait2", n < 20, 1);
    rst = 1;
    cyc();
    rst = 0;
    chk("midrst_valid", valid_d, 0);
    imem_rsp_valid = 1; imem_rsp_data = 32'hDEAD_BEEF;
    cyc();
    wait_valid("midrst_first_valid");
    chk("midrst_pc", pc_d, RST_PC);
    chk("midrst_instr", instr_d, memf(RST_PC));
    k = 1;
    repeat (3) cyc();
    // backpressure: address stays put
    imem_req_ready = 0;
    n = 0;
    while (pend && n < 10) begin cyc(); n++; end
    repeat (5) begin
      #1;
      chk("bp_req_valid", imem_req_valid, 1);
      chk("bp_addr", imem_addr, {exp_pc[31:2], 2'b00});
      cyc();
    end
    imem_req_ready = 1;
    // wrap-around target, R+3 latency
    n = 0;
    while (!(pend && rem == 1) && n < 20) begin cyc(); n++; end
    chk("reach_stream2", n < 20, 1);
    redirect_valid = 1; redirect_target = 32'hFFFF_FFFC;
    cyc();
    redirect_valid = 0;
    chk("wrap_r1", valid_d, 0);
    cyc();
    chk("wrap_r2", valid_d, 0);
    cyc();
    chk("wrap_r3", valid_d, 1);
    chk("wrap_pc", pc_d, 32'hFFFF_FFFC);
    chk("wrap_pc4", pc_plus4_d, 32'h0);
    repeat (3) cyc();
    chk("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
